// File: rtl/switch_change_encoder_pkg.sv
// Shared game definitions: the reserved idle change code and the press FSM state encoding.
// Imported by both the input encoder and the game FSM so both ends agree on IDLE_CODE.
package game_pkg;

    localparam logic [3:0] IDLE_CODE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EMIT         = 2'd1,
        WAIT_RELEASE = 2'd2,
        LOCKOUT      = 2'd3
    } game_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/switch_change_encoder_if.sv
// Pin-side inputs and game-side outputs of the switch change encoder.
// The optional echo_out signal exists only when CHANGE_ECHO_EN is defined.
interface switch_change_encoder_if;
    logic [3:0] sw_raw;
    logic       confirm_raw;
    logic       enable;
    logic [3:0] change_out;
    logic       change_valid;
    logic       reject_pulse;
    logic [7:0] press_count;
`ifdef CHANGE_ECHO_EN
    logic [3:0] echo_out;
`endif

    modport master (
        output sw_raw, confirm_raw, enable,
        input  change_out, change_valid, reject_pulse, press_count
`ifdef CHANGE_ECHO_EN
        , input echo_out
`endif
    );

    modport slave (
        input  sw_raw, confirm_raw, enable,
        output change_out, change_valid, reject_pulse, press_count
`ifdef CHANGE_ECHO_EN
        , output echo_out
`endif
    );
endinterface

// File: rtl/switch_change_encoder_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a stability counter.
// The debounced bit follows the synchronised bit after DEBOUNCE_CYCLES stable cycles.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            dout    <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // Any return to the debounced level restarts the stability window.
            if (sync_p1 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                dout <= sync_p1;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_change_encoder.sv
// Player input front end: debounces switches and confirm, emits one change code per press.
// Optional build macro CHANGE_ECHO_EN adds echo_out holding the last emitted code.
module switch_change_encoder
    import game_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         CNT_W           = 5,
    parameter int         LOCKOUT_CYCLES  = 8,
    parameter logic [3:0] IDLE_CODE       = game_pkg::IDLE_CODE
) (
    input logic                  clk,
    input logic                  reset,
    switch_change_encoder_if.slave bus
);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [3:0]        sw_deb;
    logic              confirm_deb;
    logic              confirm_deb_q;
    logic              confirm_edge;

    game_state_t       state, state_n;
    logic [3:0]        code_q, code_n;
    logic [LOCK_W-1:0] lock_cnt, lock_n;
    logic              reject_n;

    logic [3:0]        change_out_q;
    logic              change_valid_q;
    logic              reject_q;
    logic [7:0]        press_count_q;

    for (genvar i = 0; i < 4; i++) begin : g_sw_deb
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_sw (
            .clk   (clk),
            .reset (reset),
            .din   (bus.sw_raw[i]),
            .dout  (sw_deb[i])
        );
    end

    debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_confirm (
        .clk   (clk),
        .reset (reset),
        .din   (bus.confirm_raw),
        .dout  (confirm_deb)
    );

    assign confirm_edge = confirm_deb & ~confirm_deb_q;

    always_comb begin
        state_n  = state;
        code_n   = code_q;
        lock_n   = lock_cnt;
        reject_n = 1'b0;
        case (state)
            IDLE: begin
                if (confirm_edge) begin
                    // IDLE_CODE is reserved as the "no code" marker and can never be sent.
                    if (!bus.enable || (sw_deb == IDLE_CODE)) begin
                        reject_n = 1'b1;
                        state_n  = WAIT_RELEASE;
                    end else begin
                        code_n  = sw_deb;
                        state_n = EMIT;
                    end
                end
            end
            EMIT: state_n = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (!confirm_deb) begin
                    state_n = LOCKOUT;
                    lock_n  = LOCK_W'(LOCKOUT_CYCLES);
                end
            end
            LOCKOUT: begin
                if (lock_cnt == '0) state_n = IDLE;
                else                lock_n  = lock_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            code_q        <= '0;
            lock_cnt      <= '0;
            confirm_deb_q <= 1'b0;
        end else begin
            state         <= state_n;
            code_q        <= code_n;
            lock_cnt      <= lock_n;
            confirm_deb_q <= confirm_deb;
        end
    end

    // Outputs are registered from the next-state decision so they line up with the EMIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            change_out_q   <= IDLE_CODE;
            change_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            press_count_q  <= '0;
        end else begin
            change_valid_q <= (state_n == EMIT);
            change_out_q   <= (state_n == EMIT) ? code_n : IDLE_CODE;
            reject_q       <= reject_n;
            if (state == EMIT) press_count_q <= sat_inc8(press_count_q);
        end
    end

    assign bus.change_out   = change_out_q;
    assign bus.change_valid = change_valid_q;
    assign bus.reject_pulse = reject_q;
    assign bus.press_count  = press_count_q;

`ifdef CHANGE_ECHO_EN
    logic [3:0] echo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              echo_q <= '0;
        else if (state == EMIT) echo_q <= code_q;
    end

    assign bus.echo_out = echo_q;
`endif
endmodule

// File: tb/tb_switch_change_encoder.sv
// Scoreboard bench for switch_change_encoder: directed presses queue expected emits/rejects,
// a negedge monitor pops and compares them as the DUT presents change_valid or reject_pulse.
module tb_switch_change_encoder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    switch_change_encoder_if bus ();

    // Long lockout so a debounced re-press can land inside the dead time.
    switch_change_encoder #(
        .DEBOUNCE_CYCLES (16),
        .CNT_W           (5),
        .LOCKOUT_CYCLES  (32),
        .IDLE_CODE       (4'b1111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       is_rej;
        logic [3:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.change_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_emit", {28'd0, bus.change_out}, 32'hDEAD);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("emit_kind", {31'd0, e.is_rej}, 32'd0);
                    chk("emit_code", {28'd0, bus.change_out}, {28'd0, e.code});
                end
            end
            if (bus.reject_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_reject", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("reject_kind", {31'd0, e.is_rej}, 32'd1);
                end
            end
        end
    end

    task automatic set_sw(input logic [3:0] v);
        @(negedge clk);
        bus.sw_raw = v;
        repeat (25) @(negedge clk);
    endtask

    task automatic press(input int hold, input int gap);
        @(negedge clk);
        bus.confirm_raw = 1'b1;
        repeat (hold) @(negedge clk);
        bus.confirm_raw = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic push(input logic is_rej, input logic [3:0] code);
        ev_t e;
        e.is_rej = is_rej;
        e.code   = code;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [7:0] cnt_before;
        bit         seen;

        bus.sw_raw      = 4'b0000;
        bus.confirm_raw = 1'b0;
        bus.enable      = 1'b1;
        reset           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_change_out",   {28'd0, bus.change_out},   32'hF);
        chk("rst_change_valid", {31'd0, bus.change_valid}, 32'd0);
        chk("rst_reject",       {31'd0, bus.reject_pulse}, 32'd0);
        chk("rst_press_count",  {24'd0, bus.press_count},  32'd0);
        reset = 1'b0;

        // Basic press
        set_sw(4'b0101);
        push(1'b0, 4'b0101);
        press(40, 70);
        chk("basic_count", {24'd0, bus.press_count}, 32'd1);
`ifdef CHANGE_ECHO_EN
        chk("basic_echo", {28'd0, bus.echo_out}, 32'h5);
`endif

        // Reset landing in the EMIT cycle: the emit is lost
        @(negedge clk);
        bus.confirm_raw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.change_valid) seen = 1'b1;
        end
        chk("rstemit_seen_valid", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstemit_change_out",   {28'd0, bus.change_out},   32'hF);
        chk("rstemit_change_valid", {31'd0, bus.change_valid}, 32'd0);
        chk("rstemit_press_count",  {24'd0, bus.press_count},  32'd0);
        @(negedge clk);
        bus.confirm_raw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Bouncing confirm then solid hold: one emit, no reject
        set_sw(4'b1010);
        push(1'b0, 4'b1010);
        for (int i = 0; i < 10; i++) begin
            bus.confirm_raw = ~bus.confirm_raw;
            repeat (3) @(negedge clk);
        end
        press(40, 70);
        chk("bounce_count", {24'd0, bus.press_count}, 32'd1);

        // Reserved code is rejected
        set_sw(4'b1111);
        push(1'b1, 4'b0000);
        press(40, 70);
        chk("reserved_count", {24'd0, bus.press_count}, 32'd1);

        // Disabled press is rejected, then accepted once enabled
        bus.enable = 1'b0;
        set_sw(4'b0011);
        push(1'b1, 4'b0000);
        press(40, 70);
        chk("disabled_count", {24'd0, bus.press_count}, 32'd1);
        bus.enable = 1'b1;
        push(1'b0, 4'b0011);
        press(40, 70);
        chk("enabled_count", {24'd0, bus.press_count}, 32'd2);

        // Re-press whose debounced edge falls inside lockout is ignored silently
        set_sw(4'b1001);
        cnt_before = bus.press_count;
        push(1'b0, 4'b1001);
        press(40, 20);
        press(30, 70);
        chk("lockout_count", {24'd0, bus.press_count}, {24'd0, cnt_before} + 32'd1);
        chk("lockout_queue", exp_q.size(), 32'd0);

        // Saturation of press_count
        set_sw(4'b0110);
        for (int i = 0; i < 260; i++) begin
            push(1'b0, 4'b0110);
            press(40, 70);
        end
        chk("sat_count", {24'd0, bus.press_count}, 32'd255);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
